// File: rtl/dr_rx_sync.sv
`default_nettype none
// dr_rx_sync: dual-rail (two-phase or four-phase) to synchronous receiver with
// completion detection, acknowledge generation and a first-word fall-through FIFO.
module dr_rx_sync #(
    parameter int WIDTH       = 8,
    parameter     ENC         = "TP",
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0][1:0]      in,
    output logic                       ack_o,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [15:0]                count,
    output logic                       err
);
    localparam bit IS_FP = (ENC == "FP");
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_NULL = 1'b1
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
    logic [WIDTH-1:0][1:0] s;
    logic [WIDTH-1:0][1:0] rail_ref;
    logic [WIDTH-1:0][1:0] delta;
    logic [WIDTH-1:0]      word;
    logic [WIDTH-1:0]      bit_ok;
    logic [WIDTH-1:0]      bit_bad;
    logic                  complete;
    logic                  illegal;
    logic                  is_null;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  ack_next;
    logic                  ref_load;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // In FP the rails themselves are the code; in TP the code is which rail
    // moved since the last accepted token.
    for (genvar i = 0; i < WIDTH; i++) begin : g_decode
        assign delta[i]   = IS_FP ? s[i] : (s[i] ^ rail_ref[i]);
        assign bit_ok[i]  = delta[i][0] ^ delta[i][1];
        assign bit_bad[i] = delta[i][0] & delta[i][1];
        assign word[i]    = delta[i][1];
    end

    assign complete = &bit_ok;
    assign illegal  = |bit_bad;
    assign is_null  = (s == '0);
    assign full     = (level == LW'(DEPTH));
    assign pop      = out_valid & out_ready;

    always_comb begin
        state_next = state;
        ack_next   = ack_o;
        push       = 1'b0;
        ref_load   = 1'b0;
        case (state)
            IDLE: begin
                if (complete && !full) begin
                    push = 1'b1;
                    if (IS_FP) begin
                        ack_next   = 1'b1;
                        state_next = WAIT_NULL;
                    end else begin
                        ack_next = ~ack_o;
                        ref_load = 1'b1;
                    end
                end
            end
            WAIT_NULL: begin
                if (is_null) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ack_o    <= 1'b0;
            rail_ref <= '0;
            count    <= 16'd0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            ack_o <= ack_next;
            if (ref_load) begin
                rail_ref <= s;
            end
            if (push) begin
                count <= count + 16'd1;
            end
            if (illegal) begin
                err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    assign out_valid = (level != '0);
    assign out       = out_valid ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dr_rx_sync.sv
`default_nettype none
// tb_dr_rx_sync: exercises an FP and a TP instance against a queue-based token model.
module tb_dr_rx_sync;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0][1:0] fp_in, tp_in;
    logic            fp_ack, tp_ack, fp_valid, tp_valid, fp_ready, tp_ready, fp_err, tp_err;
    logic [7:0]      fp_out, tp_out;
    logic [2:0]      fp_level, tp_level;
    logic [15:0]     fp_count, tp_count;

    dr_rx_sync #(.WIDTH(8), .ENC("FP"), .DEPTH(4), .SYNC_STAGES(2)) u_fp (
        .clk(clk), .rst(rst), .in(fp_in), .ack_o(fp_ack), .out(fp_out),
        .out_valid(fp_valid), .out_ready(fp_ready), .level(fp_level),
        .count(fp_count), .err(fp_err)
    );

    dr_rx_sync #(.WIDTH(8), .ENC("TP"), .DEPTH(4), .SYNC_STAGES(2)) u_tp (
        .clk(clk), .rst(rst), .in(tp_in), .ack_o(tp_ack), .out(tp_out),
        .out_valid(tp_valid), .out_ready(tp_ready), .level(tp_level),
        .count(tp_count), .err(tp_err)
    );

    int total = 0;
    int bad   = 0;

    // reference model: tokens accepted but not yet consumed, and accepted totals
    logic [7:0] fp_q[$];
    logic [7:0] tp_q[$];
    int         fp_cnt;
    int         tp_cnt;

    task automatic reset_models();
        fp_q.delete();
        tp_q.delete();
        fp_cnt = 0;
        tp_cnt = 0;
    endtask

    task automatic fp_drive(input logic [7:0] w);
        for (int i = 0; i < 8; i++) fp_in[i] = w[i] ? 2'b10 : 2'b01;
    endtask

    task automatic tp_toggle(input logic [7:0] w);
        for (int i = 0; i < 8; i++) tp_in[i][w[i]] = ~tp_in[i][w[i]];
    endtask

    task automatic fp_send(input logic [7:0] w);
        logic seen;
        @(negedge clk);
        fp_drive(w);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (fp_ack === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL fp_ack_rise: ack_o=%b required 1 within 20 cycles", fp_ack);
        end
        fp_q.push_back(w);
        fp_cnt++;
        fp_in = '0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (fp_ack === 1'b0) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL fp_ack_fall: ack_o=%b required 0 within 20 cycles", fp_ack);
        end
    endtask

    task automatic tp_send(input logic [7:0] w);
        logic seen;
        logic old;
        @(negedge clk);
        old = tp_ack;
        tp_toggle(w);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tp_ack !== old) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL tp_ack_toggle: ack_o=%b required %b within 20 cycles", tp_ack, ~old);
        end
        tp_q.push_back(w);
        tp_cnt++;
    endtask

    task automatic fp_pop(output logic [7:0] d, output logic v);
        @(negedge clk);
        v = fp_valid;
        d = fp_out;
        fp_ready = 1'b1;
        @(negedge clk);
        fp_ready = 1'b0;
    endtask

    task automatic tp_pop(output logic [7:0] d, output logic v);
        @(negedge clk);
        v = tp_valid;
        d = tp_out;
        tp_ready = 1'b1;
        @(negedge clk);
        tp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fp_in = '0;
        tp_in = '0;
        fp_ready = 1'b0;
        tp_ready = 1'b0;
        reset_models();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({fp_ack, fp_valid, fp_level, fp_count, fp_err, fp_out} !== '0) begin
            bad++;
            $display("FAIL reset_fp: ack=%b valid=%b level=%0d count=%0d err=%b out=%h required all 0",
                     fp_ack, fp_valid, fp_level, fp_count, fp_err, fp_out);
        end
        total++;
        if ({tp_ack, tp_valid, tp_level, tp_count, tp_err, tp_out} !== '0) begin
            bad++;
            $display("FAIL reset_tp: ack=%b valid=%b level=%0d count=%0d err=%b out=%h required all 0",
                     tp_ack, tp_valid, tp_level, tp_count, tp_err, tp_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fp_latency();
        logic [7:0] d;
        logic       v;
        @(negedge clk);
        fp_drive(8'h05);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (fp_valid !== 1'b0 || fp_ack !== 1'b0) begin
            bad++;
            $display("FAIL fp_early: valid=%b ack=%b required 0 0 after 2 edges", fp_valid, fp_ack);
        end
        @(posedge clk);
        #1;
        total++;
        if (fp_valid !== 1'b1 || fp_out !== 8'h05 || fp_ack !== 1'b1 || fp_count !== 16'd1) begin
            bad++;
            $display("FAIL fp_latency: valid=%b out=%h ack=%b count=%0d required 1 05 1 1",
                     fp_valid, fp_out, fp_ack, fp_count);
        end
        fp_q.push_back(8'h05);
        fp_cnt++;
        @(negedge clk);
        fp_in = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (fp_ack !== 1'b1) begin
            bad++;
            $display("FAIL fp_null_early: ack=%b required 1 two edges after null", fp_ack);
        end
        @(posedge clk);
        #1;
        total++;
        if (fp_ack !== 1'b0) begin
            bad++;
            $display("FAIL fp_null_fall: ack=%b required 0 three edges after null", fp_ack);
        end
        fp_pop(d, v);
        total++;
        if (v !== 1'b1 || d !== fp_q[0]) begin
            bad++;
            $display("FAIL fp_latency_pop: valid=%b data=%h required 1 %h", v, d, fp_q[0]);
        end
        void'(fp_q.pop_front());
    endtask

    task automatic test_tp_repeat();
        logic [7:0] d;
        logic       v;
        tp_send(8'hA3);
        total++;
        if (tp_ack !== 1'b1) begin
            bad++;
            $display("FAIL tp_ack_first: ack=%b required 1", tp_ack);
        end
        tp_send(8'hA3);
        #1;
        total++;
        if (tp_ack !== 1'b0 || tp_count !== 16'(tp_cnt) || tp_err !== 1'b0 || tp_level !== 3'd2) begin
            bad++;
            $display("FAIL tp_repeat: ack=%b count=%0d err=%b level=%0d required 0 %0d 0 2",
                     tp_ack, tp_count, tp_err, tp_level, tp_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            tp_pop(d, v);
            total++;
            if (v !== 1'b1 || d !== 8'hA3) begin
                bad++;
                $display("FAIL tp_repeat_pop%0d: valid=%b data=%h required 1 a3", k, v, d);
            end
            void'(tp_q.pop_front());
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] d, w5, expd;
        logic       v, old;
        for (int k = 0; k < 4; k++) tp_send(8'($urandom));
        #1;
        total++;
        if (tp_level !== 3'd4) begin
            bad++;
            $display("FAIL bp_full: level=%0d required 4", tp_level);
        end
        w5 = 8'($urandom);
        @(negedge clk);
        old = tp_ack;
        tp_toggle(w5);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (tp_ack !== old || tp_level !== 3'd4 || tp_count !== 16'(tp_cnt)) begin
            bad++;
            $display("FAIL bp_withheld: ack=%b level=%0d count=%0d required %b 4 %0d",
                     tp_ack, tp_level, tp_count, old, tp_cnt);
        end
        tp_pop(d, v);
        expd = tp_q.pop_front();
        total++;
        if (v !== 1'b1 || d !== expd || tp_level !== 3'd3) begin
            bad++;
            $display("FAIL bp_pulse: valid=%b data=%h level=%0d required 1 %h 3", v, d, tp_level, expd);
        end
        @(posedge clk);
        #1;
        total++;
        if (tp_level !== 3'd4 || tp_ack === old) begin
            bad++;
            $display("FAIL bp_push5: level=%0d ack=%b required 4 %b", tp_level, tp_ack, ~old);
        end
        tp_q.push_back(w5);
        tp_cnt++;
        while (tp_q.size() > 0) begin
            expd = tp_q.pop_front();
            tp_pop(d, v);
            total++;
            if (v !== 1'b1 || d !== expd) begin
                bad++;
                $display("FAIL bp_order: valid=%b data=%h required 1 %h", v, d, expd);
            end
        end
    endtask

    task automatic test_random_tp();
        logic [7:0] d, expd;
        logic       v;
        for (int k = 0; k < 24; k++) begin
            if (tp_q.size() == 4 || (tp_q.size() > 0 && $urandom_range(1, 0) == 1)) begin
                expd = tp_q.pop_front();
                tp_pop(d, v);
                total++;
                if (v !== 1'b1 || d !== expd) begin
                    bad++;
                    $display("FAIL rand_tp_pop: valid=%b data=%h required 1 %h", v, d, expd);
                end
            end
            tp_send(8'($urandom));
            #1;
            total++;
            if (tp_level !== 3'(tp_q.size()) || tp_count !== 16'(tp_cnt)) begin
                bad++;
                $display("FAIL rand_tp_state: level=%0d count=%0d required %0d %0d",
                         tp_level, tp_count, tp_q.size(), tp_cnt);
            end
        end
        while (tp_q.size() > 0) begin
            expd = tp_q.pop_front();
            tp_pop(d, v);
            total++;
            if (v !== 1'b1 || d !== expd) begin
                bad++;
                $display("FAIL rand_tp_drain: valid=%b data=%h required 1 %h", v, d, expd);
            end
        end
    endtask

    task automatic test_random_fp();
        logic [7:0] d, expd;
        logic       v;
        for (int k = 0; k < 10; k++) begin
            if (fp_q.size() == 4 || (fp_q.size() > 0 && $urandom_range(1, 0) == 1)) begin
                expd = fp_q.pop_front();
                fp_pop(d, v);
                total++;
                if (v !== 1'b1 || d !== expd) begin
                    bad++;
                    $display("FAIL rand_fp_pop: valid=%b data=%h required 1 %h", v, d, expd);
                end
            end
            fp_send(8'($urandom));
            #1;
            total++;
            if (fp_level !== 3'(fp_q.size()) || fp_count !== 16'(fp_cnt)) begin
                bad++;
                $display("FAIL rand_fp_state: level=%0d count=%0d required %0d %0d",
                         fp_level, fp_count, fp_q.size(), fp_cnt);
            end
        end
        while (fp_q.size() > 0) begin
            expd = fp_q.pop_front();
            fp_pop(d, v);
            total++;
            if (v !== 1'b1 || d !== expd) begin
                bad++;
                $display("FAIL rand_fp_drain: valid=%b data=%h required 1 %h", v, d, expd);
            end
        end
    endtask

    task automatic test_partial();
        logic [7:0] d;
        logic       v;
        logic       seen;
        @(negedge clk);
        fp_drive(8'h5A);
        fp_in[7] = 2'b00;
        repeat (50) @(posedge clk);
        #1;
        total++;
        if (fp_level !== 3'd0 || fp_ack !== 1'b0 || fp_count !== 16'(fp_cnt)) begin
            bad++;
            $display("FAIL partial_hold: level=%0d ack=%b count=%0d required 0 0 %0d",
                     fp_level, fp_ack, fp_count, fp_cnt);
        end
        @(negedge clk);
        fp_in[7] = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (fp_level !== 3'd0) begin
            bad++;
            $display("FAIL partial_early: level=%0d required 0", fp_level);
        end
        @(posedge clk);
        #1;
        total++;
        if (fp_level !== 3'd1 || fp_ack !== 1'b1) begin
            bad++;
            $display("FAIL partial_push: level=%0d ack=%b required 1 1", fp_level, fp_ack);
        end
        fp_q.push_back(8'h5A);
        fp_cnt++;
        @(negedge clk);
        fp_in = '0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (fp_ack === 1'b0) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL partial_null: ack=%b required 0 within 20 cycles", fp_ack);
        end
        fp_pop(d, v);
        total++;
        if (v !== 1'b1 || d !== fp_q[0]) begin
            bad++;
            $display("FAIL partial_pop: valid=%b data=%h required 1 %h", v, d, fp_q[0]);
        end
        void'(fp_q.pop_front());
    endtask

    task automatic test_illegal();
        @(negedge clk);
        fp_drive(8'h3C);
        fp_in[3] = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (fp_err !== 1'b0) begin
            bad++;
            $display("FAIL illegal_early: err=%b required 0", fp_err);
        end
        @(posedge clk);
        #1;
        total++;
        if (fp_err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_err: err=%b required 1", fp_err);
        end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (fp_level !== 3'd0 || fp_ack !== 1'b0 || fp_count !== 16'(fp_cnt)) begin
            bad++;
            $display("FAIL illegal_nopush: level=%0d ack=%b count=%0d required 0 0 %0d",
                     fp_level, fp_ack, fp_count, fp_cnt);
        end
        @(negedge clk);
        fp_in = '0;
        repeat (4) @(posedge clk);
        fp_send(8'h81);
        #1;
        total++;
        if (fp_err !== 1'b1 || fp_level !== 3'd1 || fp_out !== 8'h81) begin
            bad++;
            $display("FAIL illegal_sticky: err=%b level=%0d out=%h required 1 1 81",
                     fp_err, fp_level, fp_out);
        end
        @(negedge clk);
        rst = 1'b1;
        tp_in = '0;
        reset_models();
        #1;
        total++;
        if (fp_err !== 1'b0 || fp_level !== 3'd0) begin
            bad++;
            $display("FAIL illegal_rst: err=%b level=%0d required 0 0", fp_err, fp_level);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        fp_send(8'($urandom));
        @(negedge clk);
        fp_drive(8'($urandom));
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (fp_ack === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || fp_level !== 3'd2) begin
            bad++;
            $display("FAIL mid_setup: ack=%b level=%0d required 1 2", fp_ack, fp_level);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (fp_ack !== 1'b0 || fp_valid !== 1'b0 || fp_level !== 3'd0 || fp_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset: ack=%b valid=%b level=%0d count=%0d required 0 0 0 0",
                     fp_ack, fp_valid, fp_level, fp_count);
        end
        fp_in = '0;
        tp_in = '0;
        reset_models();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fp_latency();
        test_tp_repeat();
        test_back_pressure();
        test_random_tp();
        test_partial();
        test_random_fp();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
